// File: rtl/ascon_ctrl_pkg.sv
// Shared types and constants for the Ascon permutation sequencer.
// Holds the FSM encoding, register bit positions and rounds legalisation.
package ascon_ctrl_pkg;

    localparam int STATE_W    = 320;
    localparam int N_WORDS    = 10;
    localparam int ROUNDS_MAX = 12;
    localparam int IDX_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_CAPTURE
    } state_t;

    localparam int CTRL_START = 0;
    localparam int CTRL_CLR   = 1;
    localparam int RND_LSB    = 8;
    localparam int RND_MSB    = 12;
    localparam int STAT_BUSY  = 16;
    localparam int STAT_DONE  = 17;
    localparam int STAT_ERR   = 18;
    localparam int STAT_VALID = 19;
    localparam int IDX_LSB    = 20;
    localparam int IDX_MSB    = 23;

    // Zero or out-of-range round counts fall back to the full permutation.
    function automatic logic [4:0] legal_rounds(input logic [4:0] r);
        if (r == 5'd0 || r > 5'(ROUNDS_MAX))
            return 5'(ROUNDS_MAX);
        return r;
    endfunction

endpackage

// File: rtl/perm_word_reader.sv
// Result buffer and word-serial readout towards the CPU bus.
// One ack per read, MSW first, index wraps after the last word.
module perm_word_reader
    import ascon_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               resetn,
    input  logic               cap,
    input  logic [STATE_W-1:0] perm_out,
    input  logic               valid,
    input  logic               idle,
    input  logic               reg_dat_re,
    output logic [31:0]        reg_dat_do,
    output logic               reg_dat_wait,
    output logic [IDX_W-1:0]   idx
);

    logic [STATE_W-1:0] res_q;
    logic [31:0]        word;
    logic               ack;
    logic               take;

    assign take         = reg_dat_re && idle && !ack;
    assign reg_dat_wait = reg_dat_re && !ack;

    // Select the buffer word addressed by the read index.
    always_comb begin
        word = '0;
        for (int i = 0; i < N_WORDS; i++)
            if (idx == IDX_W'(i))
                word = res_q[STATE_W-1-32*i -: 32];
    end

    // Capture the core result and serve one word per accepted read.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            res_q      <= '0;
            idx        <= '0;
            ack        <= 1'b0;
            reg_dat_do <= '0;
        end else begin
            ack <= take;
            if (cap) begin
                res_q <= perm_out;
                idx   <= '0;
            end else if (take) begin
                if (valid) begin
                    reg_dat_do <= word;
                    idx <= (idx == IDX_W'(N_WORDS - 1)) ? '0 : idx + 1'b1;
                end else begin
                    reg_dat_do <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/ascon_perm_ctrl.sv
// Sequencer between the memory-mapped Ascon state and the permutation core.
// Launches the core, waits with a timeout, then exposes the result wordwise.
module ascon_perm_ctrl
    import ascon_ctrl_pkg::*;
#(
    parameter int ROUNDS_DEFAULT = 12,
    parameter int TIMEOUT        = 63
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [3:0]         reg_ctrl_we,
    input  logic [31:0]        reg_ctrl_di,
    output logic [31:0]        reg_ctrl_do,
    input  logic [STATE_W-1:0] s_in,
    input  logic               reg_dat_re,
    output logic [31:0]        reg_dat_do,
    output logic               reg_dat_wait,
    output logic               perm_start,
    output logic [4:0]         perm_rounds,
    output logic [STATE_W-1:0] perm_s,
    input  logic [STATE_W-1:0] perm_out,
    input  logic               perm_done
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [4:0]       rounds;
    logic [4:0]       rounds_nxt;
    logic             done;
    logic             err;
    logic             valid;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic             start_wr;
    logic             clr_wr;
    logic             idle;
    logic             unused_ok;

    assign start_wr  = reg_ctrl_we[0] && reg_ctrl_di[CTRL_START];
    assign clr_wr    = reg_ctrl_we[0] && reg_ctrl_di[CTRL_CLR];
    assign idle      = (state == ST_IDLE);
    assign unused_ok = ^{reg_ctrl_we[3:2], reg_ctrl_di[31:13],
                         reg_ctrl_di[7:2]};

    // A round count written together with START takes effect at once.
    always_comb begin
        rounds_nxt = rounds;
        if (reg_ctrl_we[1])
            rounds_nxt = legal_rounds(reg_ctrl_di[RND_MSB:RND_LSB]);
    end

    // Programmable round count register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            rounds <= 5'(ROUNDS_DEFAULT);
        else
            rounds <= rounds_nxt;
    end

    // Launch / wait / capture sequencing with registered core interface.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            perm_start  <= 1'b0;
            perm_rounds <= 5'(ROUNDS_DEFAULT);
            perm_s      <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
            valid       <= 1'b0;
            cnt         <= '0;
        end else begin
            perm_start <= 1'b0;
            if (clr_wr) begin
                done <= 1'b0;
                err  <= 1'b0;
            end
            unique case (state)
                ST_IDLE: begin
                    if (start_wr) begin
                        state       <= ST_LAUNCH;
                        perm_start  <= 1'b1;
                        perm_s      <= s_in;
                        perm_rounds <= rounds_nxt;
                        done        <= 1'b0;
                        err         <= 1'b0;
                        valid       <= 1'b0;
                    end
                end
                ST_LAUNCH: begin
                    state <= ST_WAIT;
                    cnt   <= '0;
                end
                ST_WAIT: begin
                    if (perm_done) begin
                        state <= ST_CAPTURE;
                    end else if (cnt == CNT_LAST) begin
                        err   <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    valid <= 1'b1;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Control/status readback assembled from live register state.
    always_comb begin
        reg_ctrl_do                   = '0;
        reg_ctrl_do[RND_MSB:RND_LSB]  = rounds;
        reg_ctrl_do[STAT_BUSY]        = !idle;
        reg_ctrl_do[STAT_DONE]        = done;
        reg_ctrl_do[STAT_ERR]         = err;
        reg_ctrl_do[STAT_VALID]       = valid;
        reg_ctrl_do[IDX_MSB:IDX_LSB]  = idx;
    end

    perm_word_reader u_reader (
        .clk          (clk),
        .resetn       (resetn),
        .cap          (state == ST_CAPTURE),
        .perm_out     (perm_out),
        .valid        (valid),
        .idle         (idle),
        .reg_dat_re   (reg_dat_re),
        .reg_dat_do   (reg_dat_do),
        .reg_dat_wait (reg_dat_wait),
        .idx          (idx)
    );

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Directed bench for ascon_perm_ctrl with a mock permutation core.
// Expected read data flows through a scoreboard queue.
module tb_ascon_perm_ctrl;

    logic         clk = 1'b0;
    logic         resetn;
    logic [3:0]   reg_ctrl_we;
    logic [31:0]  reg_ctrl_di;
    logic [31:0]  reg_ctrl_do;
    logic [319:0] s_in;
    logic         reg_dat_re;
    logic [31:0]  reg_dat_do;
    logic         reg_dat_wait;
    logic         perm_start;
    logic [4:0]   perm_rounds;
    logic [319:0] perm_s;
    logic [319:0] perm_out;
    logic         perm_done;

    int vec  = 0;
    int miss = 0;
    int starts = 0;
    logic [31:0] sb[$];
    logic [319:0] pout;
    logic [319:0] sin_a;

    always #5 clk = ~clk;

    always @(posedge clk)
        if (perm_start === 1'b1) starts++;

    ascon_perm_ctrl dut (
        .clk          (clk),
        .resetn       (resetn),
        .reg_ctrl_we  (reg_ctrl_we),
        .reg_ctrl_di  (reg_ctrl_di),
        .reg_ctrl_do  (reg_ctrl_do),
        .s_in         (s_in),
        .reg_dat_re   (reg_dat_re),
        .reg_dat_do   (reg_dat_do),
        .reg_dat_wait (reg_dat_wait),
        .perm_start   (perm_start),
        .perm_rounds  (perm_rounds),
        .perm_s       (perm_s),
        .perm_out     (perm_out),
        .perm_done    (perm_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [319:0] obs,
                       input logic [319:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] we, input logic [31:0] di);
        reg_ctrl_we = we;
        reg_ctrl_di = di;
        tick();
        reg_ctrl_we = 4'h0;
        reg_ctrl_di = 32'h0;
    endtask

    task automatic rd(input string tag, input int exp_waits);
        logic [31:0] e;
        int n;
        e = sb.pop_front();
        n = 0;
        reg_dat_re = 1'b1;
        #1;
        while (reg_dat_wait && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_stall_bound"}, 320'(n < 100), 320'(1));
        chk(tag, 320'(reg_dat_do), 320'(e));
        if (exp_waits >= 0)
            chk({tag, "_waits"}, 320'(n), 320'(exp_waits));
        reg_dat_re = 1'b0;
        tick();
    endtask

    initial begin
        resetn      = 1'b0;
        reg_ctrl_we = 4'h0;
        reg_ctrl_di = 32'h0;
        reg_dat_re  = 1'b0;
        perm_done   = 1'b0;
        s_in        = '0;
        perm_out    = '0;
        for (int i = 0; i < 10; i++) begin
            sin_a[319-32*i -: 32] = 32'h1234_5678 + 32'(i) * 32'h1111_0001;
            pout[319-32*i -: 32]  = 32'hA5C3_0F00 + 32'(i) * 32'h0101_0101;
        end

        tick();
        chk("rst_status", 320'(reg_ctrl_do), 320'(32'h0000_0C00));
        chk("rst_start", 320'(perm_start), 320'(0));
        chk("rst_rounds", 320'(perm_rounds), 320'(12));
        chk("rst_perm_s", perm_s, '0);
        chk("rst_dat_do", 320'(reg_dat_do), 320'(0));
        reg_dat_re = 1'b1;
        #1;
        chk("rst_wait_eq_re", 320'(reg_dat_wait), 320'(1));
        reg_dat_re = 1'b0;
        resetn = 1'b1;
        tick();

        sb.push_back(32'h0);
        rd("rd_empty", 1);

        wr(4'b0010, 32'(6) << 8);
        chk("rounds6", 320'(reg_ctrl_do[12:8]), 320'(6));

        s_in = sin_a;
        wr(4'b0001, 32'h1);
        chk("launch_pulse", 320'(perm_start), 320'(1));
        chk("launch_rounds", 320'(perm_rounds), 320'(6));
        chk("launch_s", perm_s, sin_a);
        chk("launch_busy", 320'(reg_ctrl_do[16]), 320'(1));
        s_in = '0;
        tick();
        chk("wait_nopulse", 320'(perm_start), 320'(0));
        wr(4'b0001, 32'h1);
        for (int i = 0; i < 6; i++) tick();
        perm_done = 1'b1;
        perm_out  = pout;
        tick();
        perm_done = 1'b0;
        chk("capt_busy", 320'(reg_ctrl_do[19:16]), 320'(4'b0001));
        tick();
        chk("done_flags", 320'(reg_ctrl_do[19:16]), 320'(4'b1010));
        chk("one_start", 320'(starts), 320'(1));
        chk("perm_s_kept", perm_s, sin_a);
        chk("idx0", 320'(reg_ctrl_do[23:20]), 320'(0));
        perm_out = '0;

        for (int i = 0; i < 10; i++) begin
            sb.push_back(pout[319-32*i -: 32]);
            rd($sformatf("word%0d", i), 1);
            chk($sformatf("idx_after%0d", i), 320'(reg_ctrl_do[23:20]),
                320'((i + 1) % 10));
        end
        sb.push_back(pout[319 -: 32]);
        rd("word_wrap", 1);

        perm_done = 1'b1;
        tick();
        perm_done = 1'b0;
        tick();
        chk("stray_done", 320'(reg_ctrl_do[19:16]), 320'(4'b1010));
        chk("stray_nostart", 320'(starts), 320'(1));

        wr(4'b0010, 32'h0);
        chk("rounds0_legal", 320'(reg_ctrl_do[12:8]), 320'(12));
        wr(4'b0010, 32'(15) << 8);
        chk("rounds15_legal", 320'(reg_ctrl_do[12:8]), 320'(12));
        wr(4'b0010, 32'(5) << 8);
        wr(4'b0001, 32'h2);
        chk("clr_flags", 320'(reg_ctrl_do[19:16]), 320'(4'b1000));

        wr(4'b0001, 32'h1);
        tick();
        for (int i = 0; i < 62; i++) tick();
        chk("to_before", 320'(reg_ctrl_do[18:16]), 320'(3'b001));
        tick();
        chk("to_err", 320'(reg_ctrl_do[19:16]), 320'(4'b0100));
        sb.push_back(32'h0);
        rd("rd_after_err", 1);

        wr(4'b0001, 32'h1);
        tick();
        sb.push_back(32'h0);
        rd("rd_stall_busy", -1);
        wr(4'b0001, 32'h3);
        tick();
        tick();
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_start", 320'(perm_start), 320'(0));
        chk("arst_status", 320'(reg_ctrl_do), 320'(32'h0000_0C00));
        chk("arst_rounds", 320'(perm_rounds), 320'(12));
        chk("arst_perm_s", perm_s, '0);
        chk("arst_dat_do", 320'(reg_dat_do), 320'(0));
        tick();
        resetn = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule

// File: doc/ascon_perm_ctrl.md
# ascon_perm_ctrl

Sequencer between the PicoSoC memory-mapped Ascon state registers and the 320-bit permutation core. It snapshots the 320-bit input state, launches the core with a programmable round count and waits for completion, guarded by a timeout. It then captures the result and streams it back to the CPU one 32-bit word per bus read. Status, including busy, done and error, is exposed through a single control/status register.

## Interface
- `ROUNDS_DEFAULT`, 12: round count after reset.
- `TIMEOUT`, 63: maximum cycles spent in WAIT before ERR is raised.
- `clk` in 1: system clock; the only clock.
- `resetn` in 1: asynchronous, active-low reset.
- `reg_ctrl_we` in 4: byte write enables for the control register.
- `reg_ctrl_di` in 32: control write data.
- `reg_ctrl_do` out 32: status readback.
- `s_in` in 320: input state; word 0 is `s_in[319:288]`.
- `reg_dat_re` in 1: result-read request (level).
- `reg_dat_do` out 32: result word.
- `reg_dat_wait` out 1: stalls the bus read.
- `perm_start` out 1: one-cycle launch pulse to the core.
- `perm_rounds` out 5: round count to the core.
- `perm_s` out 320: latched input state to the core.
- `perm_out` in 320: core result.
- `perm_done` in 1: core completion pulse.

## Operation
- Control register write fields:
  - bit0 START: write 1 to launch; the bit is not stored.
  - bit1 CLR: write 1 to clear DONE/ERR.
  - bits[12:8] ROUNDS: written when `reg_ctrl_we[1]` is set.
- ROUNDS legalisation: a value of 0 or greater than 12 is stored as 12.
- Status readback fields:
  - [12:8] ROUNDS
  - bit16 BUSY
  - bit17 DONE
  - bit18 ERR
  - bit19 VALID (result buffer holds data)
  - [23:20] read word index
- FSM states: IDLE, LAUNCH, WAIT, CAPTURE.
- IDLE:
  - START (with `reg_ctrl_we[0]`) goes to LAUNCH.
  - On the same edge: `perm_s` ← `s_in`, `perm_rounds` ← ROUNDS; DONE, ERR and VALID are cleared.
- LAUNCH: `perm_start`=1 for exactly one cycle, then go to WAIT; the timeout counter is cleared.
- WAIT:
  - On `perm_done`, go to CAPTURE.
  - Otherwise the counter increments; when it reaches TIMEOUT, set ERR and return to IDLE.
- CAPTURE: result buffer ← `perm_out`; VALID=1, DONE=1, word index=0; return to IDLE.
- BUSY=1 in LAUNCH, WAIT and CAPTURE.
- START in a non-IDLE state is ignored.
- `perm_done` outside WAIT is ignored.
- START and CLR in the same write: START wins (it clears the flags anyway).
- Readout, accepted only in IDLE:
  - `reg_dat_re` in IDLE produces an ack in the next cycle.
  - With VALID=1: `reg_dat_do` = buffer word[index], then the index increments, wrapping 9→0.
  - With VALID=0: `reg_dat_do`=0 and the index is unchanged.
- `reg_dat_wait` = `reg_dat_re` && !ack, combinational.
- A read while BUSY stalls until the FSM returns to IDLE; it then completes normally, or with 0 if ERR.
- Ack is a single-cycle pulse and cannot reassert in the cycle after it.

## Timing
- Reset values:
  - FSM state IDLE.
  - `perm_start` 0.
  - `perm_rounds` = ROUNDS_DEFAULT; ROUNDS field = ROUNDS_DEFAULT.
  - `perm_s` 0 and result buffer 0.
  - `reg_dat_do` 0; BUSY, DONE, ERR and VALID 0; index 0.
  - `reg_ctrl_do` = {12'h0, 20'h0 with ROUNDS in [12:8]}.
  - `reg_dat_wait` = `reg_dat_re`.
- START written in cycle T:
  - `perm_start` high in T+1.
  - WAIT from T+2.
  - `perm_done` in cycle D: DONE and VALID visible in D+2.
- Read latency: one wait cycle per word when in IDLE.
- Timeout: ERR is set after exactly TIMEOUT cycles in WAIT with no `perm_done`.
- Reset asserted mid-operation: the FSM returns to IDLE immediately; `perm_start` drops asynchronously; the result buffer is invalidated.
- All registered outputs change only on the `clk` rising edge, except during reset.

## Structure
- Package `ascon_ctrl_pkg` holds:
  - the FSM state enum;
  - control/status bit positions;
  - `ROUNDS_MAX`=12, `N_WORDS`=10, `STATE_W`=320.
- One sub-module, `perm_word_reader`: result buffer, word index, wrap logic, and the `reg_dat` ack/wait handshake. It takes VALID and IDLE as inputs.

## Test plan
- Reset, then a status read → `reg_ctrl_do` shows ROUNDS=12 and all flags 0; `reg_dat_re` returns 0 after one wait cycle.
- Write ROUNDS=6 and START with `s_in`=320'h1234…; core mock asserts `perm_done` 8 cycles later → `perm_start` pulses once, `perm_rounds`=6, DONE=1, VALID=1.
- Ten consecutive reads after done → words return MSW-first matching `perm_out`; an 11th read returns word 0 again; the index field wraps 9→0.
- Write ROUNDS=0, then ROUNDS=15 → ROUNDS reads back 12 both times.
- Core mock never asserts `perm_done` → ERR=1 exactly 63 cycles after entering WAIT; BUSY=0; reads return 0.
- START while BUSY plus a stray `perm_done` while IDLE → both ignored, with no second `perm_start`; `resetn` pulsed low during WAIT → all outputs return to their reset values immediately.
